// File: rtl/gate_1q_engine.sv
// gate_1q_engine: applies a 2x2 complex unitary (Q1.(WIDTH-1)) to one target
// qubit of a state vector held in a dual-port memory, one amplitude pair per
// RD/MUL/WR triplet, writing the rotated pair back in place.
//
// Build option: define GATE_SAT_EN to saturate results to the WIDTH-bit range;
// without it results wrap (low WIDTH bits kept).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, target     request (IDLE only) and target qubit, sampled together
//   uXY_r/uXY_i       signed gate coefficients, sampled with start
//   busy, done        in-progress flag, one-cycle completion pulse
//   sm_we_a/b         write enables, port A = i0, port B = i1
//   sm_addr_a/b       amplitude addresses
//   sm_din_*          write data (zero outside the write cycle)
//   sm_dout_*         read data, combinational from address
module gate_1q_engine #(
  parameter int unsigned N_QUBITS = 4,
  parameter int unsigned WIDTH    = 16
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            start,
  input  logic [(N_QUBITS > 1 ? $clog2(N_QUBITS) : 1)-1:0] target,
  input  logic signed [WIDTH-1:0]                         u00_r,
  input  logic signed [WIDTH-1:0]                         u00_i,
  input  logic signed [WIDTH-1:0]                         u01_r,
  input  logic signed [WIDTH-1:0]                         u01_i,
  input  logic signed [WIDTH-1:0]                         u10_r,
  input  logic signed [WIDTH-1:0]                         u10_i,
  input  logic signed [WIDTH-1:0]                         u11_r,
  input  logic signed [WIDTH-1:0]                         u11_i,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            sm_we_a,
  output logic                                            sm_we_b,
  output logic [N_QUBITS-1:0]                             sm_addr_a,
  output logic [N_QUBITS-1:0]                             sm_addr_b,
  output logic signed [WIDTH-1:0]                         sm_din_a_r,
  output logic signed [WIDTH-1:0]                         sm_din_a_i,
  output logic signed [WIDTH-1:0]                         sm_din_b_r,
  output logic signed [WIDTH-1:0]                         sm_din_b_i,
  input  logic signed [WIDTH-1:0]                         sm_dout_a_r,
  input  logic signed [WIDTH-1:0]                         sm_dout_a_i,
  input  logic signed [WIDTH-1:0]                         sm_dout_b_r,
  input  logic signed [WIDTH-1:0]                         sm_dout_b_i
);

  localparam int unsigned TW    = (N_QUBITS > 1) ? $clog2(N_QUBITS) : 1;
  localparam int unsigned AW    = N_QUBITS;
  localparam int unsigned KW    = (N_QUBITS > 1) ? N_QUBITS - 1 : 1;
  localparam int unsigned NPAIR = (1 << N_QUBITS) / 2;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned SW    = 2 * WIDTH + 2;
  localparam bit          TGT_CAN_OOR = (N_QUBITS < (1 << TW));

  localparam logic signed [SW-1:0] RND  = SW'(1) <<< (WIDTH - 2);
  localparam logic signed [SW-1:0] SMAX = (SW'(1) <<< (WIDTH - 1)) - SW'(1);
  localparam logic signed [SW-1:0] SMIN = -SMAX - SW'(1);

  typedef enum logic [2:0] {IDLE, RD, MUL, WR, DONE} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [TW-1:0]   tgt_q, tgt_d;
  logic            busy_q, busy_d, done_q, done_d, we_q, we_d;
  logic [AW-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic            accept;

  logic signed [WIDTH-1:0] ur_q [4];
  logic signed [WIDTH-1:0] ui_q [4];
  logic signed [WIDTH-1:0] ar_q [2];
  logic signed [WIDTH-1:0] ai_q [2];
  logic signed [PW-1:0]    prod_q [16];
  logic signed [SW-1:0]    sum_re [2];
  logic signed [SW-1:0]    sum_im [2];

  // Pair index k with a zero bit inserted at the target position.
  function automatic logic [AW-1:0] ins_zero(input logic [KW-1:0] k, input logic [TW-1:0] t);
    logic [AW-1:0] kw, lo;
    kw = AW'(k);
    lo = (AW'(1) << t) - AW'(1);
    return (kw & lo) | ((kw & ~lo) << 1);
  endfunction

  // Round half-up, drop the fraction, then reduce to WIDTH bits.
  function automatic logic signed [WIDTH-1:0] rnd_reduce(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] t;
    t = (s + RND) >>> (WIDTH - 1);
`ifdef GATE_SAT_EN
    if (t > SMAX)      rnd_reduce = WIDTH'(SMAX);
    else if (t < SMIN) rnd_reduce = WIDTH'(SMIN);
    else               rnd_reduce = WIDTH'(t);
`else
    rnd_reduce = WIDTH'(t);
`endif
  endfunction

  // Next-state, pair counter and registered-output decode.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    tgt_d    = tgt_q;
    accept   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    we_d     = 1'b0;
    addr_a_d = '0;
    addr_b_d = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          tgt_d   = target;
          k_d     = '0;
          state_d = (TGT_CAN_OOR && (32'(target) >= N_QUBITS)) ? DONE : RD;
        end
      end
      RD:  state_d = MUL;
      MUL: state_d = WR;
      WR: begin
        k_d     = k_q + KW'(1);
        state_d = (k_q == KW'(NPAIR - 1)) ? DONE : RD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered, so decode them from the upcoming state.
    busy_d = (state_d == RD) || (state_d == MUL) || (state_d == WR);
    done_d = (state_d == DONE);
    we_d   = (state_d == WR);
    if (busy_d) begin
      addr_a_d = ins_zero(k_d, tgt_d);
      addr_b_d = addr_a_d | (AW'(1) << tgt_d);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      tgt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      tgt_q    <= tgt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
    end
  end

  // Datapath: coefficient latch, amplitude read, product stage.
  // Coefficient index ci = 2*row + col; products at 4*ci + {rr, ii, ri, ir}.
  always_ff @(posedge clk) begin
    if (accept) begin
      ur_q[0] <= u00_r;  ui_q[0] <= u00_i;
      ur_q[1] <= u01_r;  ui_q[1] <= u01_i;
      ur_q[2] <= u10_r;  ui_q[2] <= u10_i;
      ur_q[3] <= u11_r;  ui_q[3] <= u11_i;
    end
    if (state_q == RD) begin
      ar_q[0] <= sm_dout_a_r;  ai_q[0] <= sm_dout_a_i;
      ar_q[1] <= sm_dout_b_r;  ai_q[1] <= sm_dout_b_i;
    end
    if (state_q == MUL) begin
      for (int ci = 0; ci < 4; ci++) begin
        prod_q[4*ci+0] <= PW'(ur_q[ci]) * PW'(ar_q[ci%2]);
        prod_q[4*ci+1] <= PW'(ui_q[ci]) * PW'(ai_q[ci%2]);
        prod_q[4*ci+2] <= PW'(ur_q[ci]) * PW'(ai_q[ci%2]);
        prod_q[4*ci+3] <= PW'(ui_q[ci]) * PW'(ar_q[ci%2]);
      end
    end
  end

  // Complex row sums: n_row = u_row0*a0 + u_row1*a1.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      sum_re[r] = '0;
      sum_im[r] = '0;
      for (int c = 0; c < 2; c++) begin
        sum_re[r] = sum_re[r] + SW'(prod_q[4*(2*r+c)+0]) - SW'(prod_q[4*(2*r+c)+1]);
        sum_im[r] = sum_im[r] + SW'(prod_q[4*(2*r+c)+2]) + SW'(prod_q[4*(2*r+c)+3]);
      end
    end
  end

  // Write data, forced to zero outside the write cycle.
  always_comb begin
    sm_din_a_r = '0;
    sm_din_a_i = '0;
    sm_din_b_r = '0;
    sm_din_b_i = '0;
    if (state_q == WR) begin
      sm_din_a_r = rnd_reduce(sum_re[0]);
      sm_din_a_i = rnd_reduce(sum_im[0]);
      sm_din_b_r = rnd_reduce(sum_re[1]);
      sm_din_b_i = rnd_reduce(sum_im[1]);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sm_we_a   = we_q;
  assign sm_we_b   = we_q;
  assign sm_addr_a = addr_a_q;
  assign sm_addr_b = addr_b_q;

endmodule
